// File: rtl/dragonfang_floating_point_pkg.sv
// Shared single-precision float types for the converter front end.
package dragonfang_floating_point_pkg;

  localparam int         FP_EXP_BIAS      = 127;
  localparam logic [7:0] FP_EXP_MAX       = 8'hFF;
  localparam logic [8:0] FP_EXP_SUBNORMAL = 9'(1 - FP_EXP_BIAS);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef enum logic [2:0] {
    FC_ZERO,
    FC_SUBNORMAL,
    FC_NORMAL,
    FC_INFINITY,
    FC_QNAN,
    FC_SNAN
  } float_class_t;

  typedef struct packed {
    float_t       value;
    float_class_t cls;
    logic [8:0]   unbiased_exp;
  } staged_operand_t;

endpackage

// File: rtl/float_classifier.sv
// Combinational IEEE-754 single classifier with signed unbiased exponent.
// FLUSH_SUBNORMAL_EN: subnormals become signed zero instead of passing through.
module float_classifier
  import dragonfang_floating_point_pkg::*;
(
  input  logic [31:0]  raw,
  output float_t       value,
  output float_class_t cls,
  output logic [8:0]   unbiased_exp
);

  float_t in_fp;
  assign in_fp = raw;

  always_comb begin
    value        = in_fp;
    cls          = FC_NORMAL;
    unbiased_exp = {1'b0, in_fp.exponent} - 9'(FP_EXP_BIAS);
    if (in_fp.exponent == 8'h00) begin
      if (in_fp.mantissa == '0) begin
        cls          = FC_ZERO;
        unbiased_exp = '0;
      end else begin
`ifdef FLUSH_SUBNORMAL_EN
        value.mantissa = '0;
        cls            = FC_ZERO;
        unbiased_exp   = '0;
`else
        cls          = FC_SUBNORMAL;
        unbiased_exp = FP_EXP_SUBNORMAL;
`endif
      end
    end else if (in_fp.exponent == FP_EXP_MAX) begin
      // the default arithmetic already yields +128 here
      if (in_fp.mantissa == '0) begin
        cls = FC_INFINITY;
      end else if (in_fp.mantissa[22]) begin
        cls = FC_QNAN;
      end else begin
        cls = FC_SNAN;
      end
    end
  end

endmodule

// File: rtl/float_operand_staging_buffer.sv
// Classifying FIFO between register read and the float-to-integer converter.
// Optional FLUSH_SUBNORMAL_EN is honoured by the float_classifier sub-module.
module float_operand_staging_buffer
  import dragonfang_floating_point_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_float,
  output logic                   out_valid,
  input  logic                   out_ready,
  output float_t                 out_float,
  output float_class_t           out_class,
  output logic [8:0]             out_unbiased_exp,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(DEPTH);

  staged_operand_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  float_t          cls_value;
  float_class_t    cls_class;
  logic [8:0]      cls_exp;
  staged_operand_t classified;
  staged_operand_t head;

  float_classifier u_classifier (
    .raw          (in_float),
    .value        (cls_value),
    .cls          (cls_class),
    .unbiased_exp (cls_exp)
  );

  assign classified = '{value: cls_value, cls: cls_class, unbiased_exp: cls_exp};

  // Ready comes from occupancy alone, so a pop never frees a slot the same cycle.
  assign in_ready  = (occupancy != FULL_LEVEL);
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= classified;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Head is shown even when empty, exposing whatever sits at the read pointer.
  assign head             = mem[rd_ptr];
  assign out_float        = head.value;
  assign out_class        = head.cls;
  assign out_unbiased_exp = head.unbiased_exp;

endmodule
